// File: rtl/cmd_pkg.sv
// Shared constants and types for the command-frame decoder and config register block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_pkg;

    // Frame-hunting FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_ADDR = 3'd2,
        ST_DHI  = 3'd3,
        ST_DLO  = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    // Default sync bytes opening every frame
    localparam logic [7:0] HEAD0_DEF = 8'hEB;
    localparam logic [7:0] HEAD1_DEF = 8'h90;

    // HEAD0, HEAD1, ADDR, DHI, DLO, CHK
    localparam int FRAME_LEN = 6;

    // Number of registers in the config block; legal addresses are 0..REG_MAP_SIZE-1
    localparam int REG_MAP_SIZE = 20;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 8'hFF instead of wrapping.
// Latency: count reflects an increment one clock after inc_in is sampled high.
// Backpressure: none; every asserted inc_in cycle is counted until saturation.
module sat_cnt8 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       inc_in,
    output logic [7:0] cnt_out
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: step by one unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc_in && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/cmd_frame_decoder.sv
// Hunts framed write commands in a byte stream, validates checksum/address, issues register writes.
// Latency: wr_out / frame_err_out pulse in the cycle after the edge that samples the CHK byte.
// Backpressure: none; one byte is consumed on every cycle byte_vld_in is high.
module cmd_frame_decoder
    import cmd_pkg::*;
#(
    parameter logic [7:0] HEAD0       = HEAD0_DEF,
    parameter logic [7:0] HEAD1       = HEAD1_DEF,
    parameter logic [7:0] MAX_ADDR    = 8'(REG_MAP_SIZE - 1),
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        byte_vld_in,
    input  logic [7:0]  byte_in,
    output logic        wr_out,
    output logic [7:0]  wr_addr_out,
    output logic [15:0] data_out,
    output logic        frame_err_out,
    output logic [7:0]  frame_cnt_out,
    output logic [7:0]  err_cnt_out
);

    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    // Last gap value before expiry: an idle cycle seen at this count is the TIMEOUT_CYC-th
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    state_t             state_q,   state_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic [7:0]         addr_sh_q, addr_sh_d;
    logic [7:0]         dhi_sh_q,  dhi_sh_d;
    logic [7:0]         dlo_sh_q,  dlo_sh_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [15:0]        data_q,    data_d;
    logic               wr_q,      wr_d;
    logic               err_q,     err_d;

    logic               chk_ok;
    logic               addr_ok;

    assign chk_ok  = (byte_in == (addr_sh_q ^ dhi_sh_q ^ dlo_sh_q));
    assign addr_ok = (addr_sh_q <= MAX_ADDR);

    // Next-state logic: frame hunting, shadow capture, checksum verdict and inter-byte timeout
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        addr_sh_d = addr_sh_q;
        dhi_sh_d  = dhi_sh_q;
        dlo_sh_d  = dlo_sh_q;
        wr_addr_d = wr_addr_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        err_d     = 1'b0;

        // Gap counter only runs while a frame is open and no byte arrives;
        // a byte landing on the would-be expiry cycle wins over the timeout
        if (state_q == ST_IDLE || byte_vld_in) begin
            gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            addr_sh_d = 8'd0;
            dhi_sh_d  = 8'd0;
            dlo_sh_d  = 8'd0;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        if (byte_vld_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_in == HEAD0) state_d = ST_HDR1;
                end
                ST_HDR1: begin
                    // A repeated HEAD0 keeps us aligned on the newest candidate header
                    if (byte_in == HEAD1)      state_d = ST_ADDR;
                    else if (byte_in == HEAD0) state_d = ST_HDR1;
                    else                       state_d = ST_IDLE;
                end
                ST_ADDR: begin
                    addr_sh_d = byte_in;
                    state_d   = ST_DHI;
                end
                ST_DHI: begin
                    dhi_sh_d = byte_in;
                    state_d  = ST_DLO;
                end
                ST_DLO: begin
                    dlo_sh_d = byte_in;
                    state_d  = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (chk_ok && addr_ok) begin
                        wr_d      = 1'b1;
                        wr_addr_d = addr_sh_q;
                        data_d    = {dhi_sh_q, dlo_sh_q};
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, shadow and output registers; reset aborts any frame in flight
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            addr_sh_q <= 8'd0;
            dhi_sh_q  <= 8'd0;
            dlo_sh_q  <= 8'd0;
            wr_addr_q <= 8'd0;
            data_q    <= 16'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            addr_sh_q <= addr_sh_d;
            dhi_sh_q  <= dhi_sh_d;
            dlo_sh_q  <= dlo_sh_d;
            wr_addr_q <= wr_addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
        end
    end

    // Counters advance on the same edge that raises the matching pulse
    sat_cnt8 u_frame_cnt (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .inc_in  (wr_d),
        .cnt_out (frame_cnt_out)
    );

    sat_cnt8 u_err_cnt (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .inc_in  (err_d),
        .cnt_out (err_cnt_out)
    );

    assign wr_out        = wr_q;
    assign wr_addr_out   = wr_addr_q;
    assign data_out      = data_q;
    assign frame_err_out = err_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with hand-computed expectations.
// Latency: checks the one-cycle write/error pulse timing and timeout boundary.
// Backpressure: n/a; stimulus drives one byte per valid cycle.
module tb_cmd_frame_decoder;
    import cmd_pkg::*;

    localparam int TO = 1000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        byte_vld_in;
    logic [7:0]  byte_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;
    logic        frame_err_out;
    logic [7:0]  frame_cnt_out;
    logic [7:0]  err_cnt_out;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int wr_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int wr_cyc_last = 0;
    int wr_cyc_prev = 0;

    cmd_frame_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .byte_vld_in   (byte_vld_in),
        .byte_in       (byte_in),
        .wr_out        (wr_out),
        .wr_addr_out   (wr_addr_out),
        .data_out      (data_out),
        .frame_err_out (frame_err_out),
        .frame_cnt_out (frame_cnt_out),
        .err_cnt_out   (err_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitor: sampled on the falling edge, away from register updates
    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (wr_out) begin
            wr_seen     = wr_seen + 1;
            wr_cyc_prev = wr_cyc_last;
            wr_cyc_last = cyc;
        end
        if (frame_err_out) err_seen = err_seen + 1;
        if (wr_out && frame_err_out) both_seen = both_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_in);
        byte_vld_in = 1'b1;
        byte_in     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            byte_vld_in = 1'b0;
            byte_in     = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        send(8'hEB);
        send(8'h90);
        send(a);
        send(h);
        send(l);
        send(c);
    endtask

    // Let pending pulses drain, then step off the edge before reading monitor counts
    task automatic settle();
        idle(3);
        #1;
    endtask

    task automatic clear_seen();
        wr_seen  = 0;
        err_seen = 0;
    endtask

    logic [7:0] resync_seq [8];

    initial begin
        resync_seq = '{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h03, 8'hAA, 8'h55, 8'hFC};

        rst_in      = 1'b1;
        byte_vld_in = 1'b0;
        byte_in     = 8'h00;
        repeat (3) @(negedge clk_in);
        check("rst_wr",        32'(wr_out),        32'h0);
        check("rst_addr",      32'(wr_addr_out),   32'h0);
        check("rst_data",      32'(data_out),      32'h0);
        check("rst_err",       32'(frame_err_out), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt_out), 32'h0);
        check("rst_err_cnt",   32'(err_cnt_out),   32'h0);
        rst_in = 1'b0;
        idle(2);
        #1 clear_seen();

        // Good frame, with exact pulse timing
        send_frame(8'h05, 8'h12, 8'h34, 8'h23);
        idle(1);
        check("good_wr_latency",  32'(wr_out),        32'h1);
        check("good_err_low",     32'(frame_err_out), 32'h0);
        idle(1);
        check("good_wr_one_cyc",  32'(wr_out),        32'h0);
        settle();
        check("good_wr_count",  32'(wr_seen),       32'd1);
        check("good_err_count", 32'(err_seen),      32'd0);
        check("good_addr",      32'(wr_addr_out),   32'h05);
        check("good_data",      32'(data_out),      32'h1234);
        check("good_frame_cnt", 32'(frame_cnt_out), 32'd1);
        check("good_err_cnt",   32'(err_cnt_out),   32'd0);
        clear_seen();

        // Bad checksum
        send_frame(8'h05, 8'h12, 8'h34, 8'h00);
        idle(1);
        check("badchk_err_latency", 32'(frame_err_out), 32'h1);
        settle();
        check("badchk_err_pulses", 32'(err_seen),    32'd1);
        check("badchk_no_wr",      32'(wr_seen),     32'd0);
        check("badchk_err_cnt",    32'(err_cnt_out), 32'd1);
        check("badchk_addr_hold",  32'(wr_addr_out), 32'h05);
        check("badchk_data_hold",  32'(data_out),    32'h1234);
        clear_seen();

        // Address 20 is one past the register map
        send_frame(8'h14, 8'h00, 8'h01, 8'h15);
        settle();
        check("range_err_pulses", 32'(err_seen),      32'd1);
        check("range_no_wr",      32'(wr_seen),       32'd0);
        check("range_err_cnt",    32'(err_cnt_out),   32'd2);
        check("range_frame_cnt",  32'(frame_cnt_out), 32'd1);
        clear_seen();

        // Garbage then a doubled HEAD0 before a valid frame
        foreach (resync_seq[i]) send(resync_seq[i]);
        settle();
        check("resync_wr_count", 32'(wr_seen),     32'd1);
        check("resync_no_err",   32'(err_seen),    32'd0);
        check("resync_addr",     32'(wr_addr_out), 32'h03);
        check("resync_data",     32'(data_out),    32'hAA55);
        clear_seen();

        // Back-to-back frames with no dead cycles
        send_frame(8'h01, 8'h00, 8'h02, 8'h03);
        send_frame(8'h13, 8'hFF, 8'h00, 8'hEC);
        settle();
        check("b2b_wr_count",  32'(wr_seen),                   32'd2);
        check("b2b_spacing",   32'(wr_cyc_last - wr_cyc_prev), 32'(FRAME_LEN));
        check("b2b_addr",      32'(wr_addr_out),               32'h13);
        check("b2b_data",      32'(data_out),                  32'hFF00);
        check("b2b_frame_cnt", 32'(frame_cnt_out),             32'd4);
        clear_seen();

        // HEAD0 inside the payload is data, not a new header
        send_frame(8'h00, 8'hEB, 8'h00, 8'hEB);
        settle();
        check("head0_data_wr",   32'(wr_seen),  32'd1);
        check("head0_data_data", 32'(data_out), 32'hEB00);
        clear_seen();

        // Timeout: TO idle cycles inside a frame
        send(8'hEB);
        send(8'h90);
        send(8'h02);
        idle(TO);
        #1;
        check("to_not_early", 32'(err_seen), 32'd0);
        @(negedge clk_in);
        check("to_err_pulse", 32'(frame_err_out), 32'h1);
        settle();
        check("to_err_cnt", 32'(err_cnt_out), 32'd3);
        check("to_no_wr",   32'(wr_seen),     32'd0);
        clear_seen();

        // A byte arriving on the would-be expiry cycle keeps the frame alive
        send(8'hEB);
        send(8'h90);
        send(8'h02);
        idle(TO - 1);
        send(8'h12);
        send(8'h34);
        send(8'h24);
        settle();
        check("to_edge_no_err", 32'(err_seen),      32'd0);
        check("to_edge_wr",     32'(wr_seen),       32'd1);
        check("to_edge_addr",   32'(wr_addr_out),   32'h02);
        check("to_edge_data",   32'(data_out),      32'h1234);
        check("to_edge_fcnt",   32'(frame_cnt_out), 32'd6);
        clear_seen();

        // Error counter saturation
        for (int i = 0; i < 260; i++) send_frame(8'h05, 8'h12, 8'h34, 8'h00);
        settle();
        check("sat_err_cnt",    32'(err_cnt_out),   32'd255);
        check("sat_err_pulses", 32'(err_seen),      32'd260);
        check("sat_frame_cnt",  32'(frame_cnt_out), 32'd6);
        clear_seen();

        // Asynchronous reset in the middle of a frame
        send(8'hEB);
        send(8'h90);
        send(8'h05);
        @(negedge clk_in);
        byte_vld_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("mid_rst_addr", 32'(wr_addr_out),   32'h0);
        check("mid_rst_data", 32'(data_out),      32'h0);
        check("mid_rst_fcnt", 32'(frame_cnt_out), 32'd0);
        check("mid_rst_ecnt", 32'(err_cnt_out),   32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1 clear_seen();
        send(8'h12);
        send(8'h34);
        send(8'h23);
        settle();
        check("post_rst_tail_no_wr",  32'(wr_seen),  32'd0);
        check("post_rst_tail_no_err", 32'(err_seen), 32'd0);
        send_frame(8'h05, 8'h12, 8'h34, 8'h23);
        settle();
        check("post_rst_addr", 32'(wr_addr_out),   32'h05);
        check("post_rst_data", 32'(data_out),      32'h1234);
        check("post_rst_fcnt", 32'(frame_cnt_out), 32'd1);
        check("post_rst_ecnt", 32'(err_cnt_out),   32'd0);

        check("wr_err_exclusive", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
